seed_bitmap_ctrl: RTL

//  Multi-context seed/nonce bitmap: one bit per seed index per context, stored in a word-wide RAM.

---
 rtl/seed_bitmap_pkg.sv | 17 +
 rtl/seed_bitmap_ctrl_if.sv | 30 +++
 rtl/seed_bitmap_sdpram.sv | 18 +
 rtl/seed_bitmap_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/seed_bitmap_pkg.sv
// seed_bitmap_pkg: shared encodings, FSM states and width helpers for the seed bitmap
package seed_bitmap_pkg;
  typedef enum logic {OP_TEST = 1'b0, OP_TEST_SET = 1'b1} op_t;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int idx_w(input int dw, input int aw);
    return aw + clog2(dw);
  endfunction
  function automatic bit is_pow2(input int v);
    return v >= 2 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/seed_bitmap_ctrl_if.sv
// seed_bitmap_ctrl_if: clear-trigger and test/test-and-set request/response bundle
interface seed_bitmap_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int NCTX = 4
);
  import seed_bitmap_pkg::*;
  localparam int CW = clog2(NCTX);
  localparam int IW = idx_w(DW, AW);
  logic          clr_req;
  logic          clr_all;
  logic [CW-1:0] clr_ctx;
  logic          clr_busy;
  logic          clr_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [CW-1:0] req_ctx;
  logic [IW-1:0] req_idx;
  logic          rsp_valid;
  logic          rsp_hit;
  modport slave (
    input  clr_req, clr_all, clr_ctx, req_valid, req_op, req_ctx, req_idx,
    output clr_busy, clr_done, req_ready, rsp_valid, rsp_hit
  );
  modport master (
    output clr_req, clr_all, clr_ctx, req_valid, req_op, req_ctx, req_idx,
    input  clr_busy, clr_done, req_ready, rsp_valid, rsp_hit
  );
endinterface

// File: rtl/seed_bitmap_sdpram.sv
// seed_bitmap_sdpram: 1R1W RAM, registered read, read-during-write returns old data
module seed_bitmap_sdpram #(
  parameter int W = 32,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] r_mem [2**A];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/seed_bitmap_ctrl.sv
// seed_bitmap_ctrl: multi-context seed bitmap with pipelined test-and-set and clear sweep
module seed_bitmap_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int NCTX = 4
) (
  input logic clk,
  input logic rst,
  seed_bitmap_ctrl_if.slave bus
);
  import seed_bitmap_pkg::*;
  localparam int DB = clog2(DW);
  localparam int CW = clog2(NCTX);
  localparam int IW = idx_w(DW, AW);
  localparam int RA = CW + AW;
  if (!is_pow2(NCTX) || !is_pow2(DW)) begin : g_bad_param
    $error("seed_bitmap_ctrl: NCTX and DW must be powers of two >= 2");
  end
  state_t          r_state, w_next;
  logic [RA-1:0]   r_cnt;
  logic            r_all, r_done;
  logic            r_s1_valid, r_s1_fwd;
  op_t             r_s1_op;
  logic [RA-1:0]   r_s1_addr;
  logic [DB-1:0]   r_s1_bit;
  logic [DW-1:0]   r_s1_fwd_data;
  logic            w_acc, w_last, w_s1_we, w_fwd, w_we;
  logic [RA-1:0]   w_s0_addr, w_waddr;
  logic [DW-1:0]   w_rdata, w_old, w_s1_wdata, w_wdata;
  assign w_acc      = bus.req_valid && bus.req_ready;
  assign w_s0_addr  = {bus.req_ctx, bus.req_idx[IW-1:DB]};
  // S1 sees the word it would have read had the previous RMW write already landed
  assign w_old      = r_s1_fwd ? r_s1_fwd_data : w_rdata;
  assign w_s1_wdata = w_old | (DW'(1) << r_s1_bit);
  assign w_s1_we    = r_s1_valid && r_s1_op == OP_TEST_SET;
  assign w_fwd      = w_s1_we && w_s0_addr == r_s1_addr;
  assign w_last     = r_all ? r_cnt == '0 : r_cnt[AW-1:0] == '0;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb w_next = r_state == IDLE ? (bus.clr_req ? CLEAR : IDLE) : (w_last ? IDLE : CLEAR);
  always_comb begin
    bus.clr_busy  = r_state == CLEAR;
    bus.clr_done  = r_done;
    bus.req_ready = r_state == IDLE && !bus.clr_req;
    bus.rsp_valid = r_s1_valid;
    bus.rsp_hit   = r_s1_valid && w_old[r_s1_bit];
    w_we          = r_state == CLEAR || w_s1_we;
    w_waddr       = r_state == CLEAR ? r_cnt : r_s1_addr;
    w_wdata       = r_state == CLEAR ? '0 : w_s1_wdata;
  end
  // Sweep runs from the top word of the range down to its base word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_all  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == CLEAR && w_last;
      if (r_state == IDLE && bus.clr_req) begin
        r_all <= bus.clr_all;
        r_cnt <= bus.clr_all ? '1 : {bus.clr_ctx, {AW{1'b1}}};
      end else if (r_state == CLEAR && !w_last) begin
        r_cnt <= r_cnt - RA'(1);
      end
    end
  end
  always_ff @(posedge clk) r_s1_valid <= rst ? 1'b0 : w_acc;
  always_ff @(posedge clk) begin
    r_s1_op       <= op_t'(bus.req_op);
    r_s1_addr     <= w_s0_addr;
    r_s1_bit      <= bus.req_idx[DB-1:0];
    r_s1_fwd      <= w_fwd;
    r_s1_fwd_data <= w_s1_wdata;
  end
  seed_bitmap_sdpram #(.W(DW), .A(RA)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_s0_addr),
    .o_rdata (w_rdata)
  );
endmodule
